md_issue_ctrl: RTL

//  Issue/stall controller for the HI/LO multiply-divide unit in the 5-stage pipeline.

---
 rtl/md_issue_ctrl_pkg.sv | 34 +++
 rtl/md_issue_ctrl_if.sv | 29 ++
 rtl/md_issue_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared funct codes, FSM state type and latency helpers for the HI/LO multiply-divide issue logic.
package md_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int DEF_CNT_W       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic IS_LONG(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic IS_MT(input logic [5:0] f);
        return (f == FUNCT_MTHI) || (f == FUNCT_MTLO);
    endfunction

    // Only meaningful for long ops; anything that is not a multiply gets the divide time.
    function automatic int LAT_OF(input logic [5:0] f, input int mult_cycles, input int div_cycles);
        return ((f == FUNCT_MULT) || (f == FUNCT_MULTU)) ? mult_cycles : div_cycles;
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline <-> md issue controller signal bundle; master is the pipeline side.
interface md_issue_ctrl_if;

    logic        e_md_valid;
    logic [5:0]  e_funct;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;

    logic        md_start;
    logic [5:0]  md_funct;
    logic [31:0] md_in1;
    logic [31:0] md_in2;
    logic        busy;
    logic        stall;
    logic [31:0] stall_cnt;
    logic        proto_err;

    modport master (
        output e_md_valid, e_funct, e_rs, e_rt, d_md_use,
        input  md_start, md_funct, md_in1, md_in2, busy, stall, stall_cnt, proto_err
    );

    modport slave (
        input  e_md_valid, e_funct, e_rs, e_rt, d_md_use,
        output md_start, md_funct, md_in1, md_in2, busy, stall, stall_cnt, proto_err
    );

endinterface

// File: rtl/md_issue_ctrl.sv
// Issues E-stage mult/div/mthi/mtlo to the HI/LO unit, tracks its latency and stalls D on HI/LO use.
// start/stall are combinational from E/D inputs; busy, stall_cnt and proto_err are registered.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    md_issue_ctrl_if.slave  bus
);

    md_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic [31:0]       stall_cnt_q;
    logic              proto_err_q;

    logic              long_op;
    logic              mt_op;
    logic              start;
    logic              stall;
    logic              illegal;
    logic [CNT_W-1:0]  lat;

    assign long_op = IS_LONG(bus.e_funct);
    assign mt_op   = IS_MT(bus.e_funct);
    assign lat     = CNT_W'(LAT_OF(bus.e_funct, MULT_CYCLES, DIV_CYCLES));

    // A valid E instruction while the unit is busy means the stall was ignored upstream.
    assign start   = bus.e_md_valid & ~busy_q & (long_op | mt_op);
    assign illegal = bus.e_md_valid & (busy_q | ~(long_op | mt_op));

    // mthi/mtlo land on the issuing edge, so only long ops hold D.
    assign stall   = bus.d_md_use & (busy_q | (start & long_op));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && long_op) begin
                        state  <= ST_RUN;
                        cnt    <= lat;
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase

            if (illegal)
                proto_err_q <= 1'b1;

            if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.md_start  = start;
    assign bus.md_funct  = bus.e_funct;
    assign bus.md_in1    = bus.e_rs;
    assign bus.md_in2    = bus.e_rt;
    assign bus.busy      = busy_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.proto_err = proto_err_q;

endmodule
